// File: rtl/ifetch_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_bridge_pkg
//  Description : Shared FSM encoding and constants for the instruction-fetch
//                bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifetch_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    localparam logic [31:0] c_RESET_VEC = 32'hBFC00000;
    localparam logic [4:0]  EXC_ADEL    = 5'h04;

endpackage
`default_nettype wire

// File: rtl/ifetch_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_bridge
//  Description : Single-outstanding fetch bridge from the PC stage to an
//                sram-like instruction bus, with flush/drop handling.
//                Optional macro IFETCH_ALIGN_CHECK_EN adds the misaligned
//                fetch (AdEL) check and the adel_o port.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch_bridge
    import ifetch_bridge_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VEC = DATA_W'(c_RESET_VEC)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              fetch_en,
    input  logic              flush,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid,
    output logic              stall_o,
`ifdef IFETCH_ALIGN_CHECK_EN
    output logic              adel_o,
`endif
    output logic              bus_req,
    output logic [DATA_W-1:0] bus_addr,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_drop;
    logic              w_drop_nxt;
    logic [DATA_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_inst;
    logic              r_inst_valid;
    logic              w_fetch_go;
    logic              w_capture;
    logic              w_deliver;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic              r_adel;
    logic              w_adel;
`endif

    // No new fetch in the delivery cycle: pc_i there still holds the PC just returned.
    assign w_fetch_go = fetch_en && !flush && !r_inst_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        w_capture   = 1'b0;
        w_deliver   = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        w_adel      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_fetch_go) begin
`ifdef IFETCH_ALIGN_CHECK_EN
                    if (pc_i[1:0] != 2'b00) begin
                        w_adel = 1'b1;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_ADDR;
                    end
`else
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ADDR;
`endif
                end
            end
            ST_ADDR: begin
                // The address handshake always completes; a flush only dooms the data.
                if (bus_addr_ok) begin
                    w_state_nxt = (r_drop || flush) ? ST_DROP : ST_WAIT;
                    w_drop_nxt  = 1'b0;
                end else if (flush) begin
                    w_drop_nxt  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus_data_ok) begin
                    w_deliver   = !flush;
                    w_state_nxt = ST_IDLE;
                end else if (flush) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (bus_data_ok) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_drop       <= 1'b0;
            r_bus_addr   <= RESET_VEC;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            r_adel       <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            if (w_capture) begin
                r_bus_addr <= pc_i;
            end
`ifdef IFETCH_ALIGN_CHECK_EN
            r_adel       <= w_adel;
            r_inst_valid <= w_deliver || w_adel;
            if (w_deliver) begin
                r_inst <= bus_rdata;
            end else if (w_adel) begin
                r_inst <= '0;
            end
`else
            r_inst_valid <= w_deliver;
            if (w_deliver) begin
                r_inst <= bus_rdata;
            end
`endif
        end
    end

    assign bus_req    = (r_state == ST_ADDR);
    assign bus_addr   = r_bus_addr;
    assign inst_o     = r_inst;
    assign inst_valid = r_inst_valid;
    assign stall_o    = !r_inst_valid &&
                        ((r_state != ST_IDLE) || (fetch_en && !flush));
`ifdef IFETCH_ALIGN_CHECK_EN
    assign adel_o     = r_adel;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_bridge
//  Description : Self-checking bench for ifetch_bridge: transaction-level
//                reference model plus directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_bridge;

    localparam int          DW  = 32;
    localparam logic [31:0] RV  = 32'hBFC00000;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pc_i;
    logic          fetch_en;
    logic          flush;
    logic [DW-1:0] inst_o;
    logic          inst_valid;
    logic          stall_o;
    logic          bus_req;
    logic [DW-1:0] bus_addr;
    logic          bus_addr_ok;
    logic          bus_data_ok;
    logic [DW-1:0] bus_rdata;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic          adel_o;
`endif

    int n_pass  = 0;
    int n_total = 0;

    ifetch_bridge #(.DATA_W(DW), .RESET_VEC(RV)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .inst_o      (inst_o),
        .inst_valid  (inst_valid),
        .stall_o     (stall_o),
`ifdef IFETCH_ALIGN_CHECK_EN
        .adel_o      (adel_o),
`endif
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: one transaction object with an address phase, a data
    // phase and a "doomed" mark for data that must never reach the CPU.
    bit          t_active, t_addr_done, t_doomed;
    logic [31:0] m_addr, m_inst;
    bit          m_valid, m_adel;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_active = 0; t_addr_done = 0; t_doomed = 0;
            m_addr = RV; m_inst = 0; m_valid = 0; m_adel = 0;
        end else begin
            bit nv, na;
            logic [31:0] ni;
            nv = 0; na = 0; ni = m_inst;
            if (!t_active) begin
                if (fetch_en && !flush && !m_valid) begin
`ifdef IFETCH_ALIGN_CHECK_EN
                    if (pc_i[1:0] != 0) begin
                        nv = 1; na = 1; ni = 0;
                    end else begin
                        t_active = 1; t_addr_done = 0; t_doomed = 0; m_addr = pc_i;
                    end
`else
                    t_active = 1; t_addr_done = 0; t_doomed = 0; m_addr = pc_i;
`endif
                end
            end else if (!t_addr_done) begin
                if (flush)       t_doomed = 1;
                if (bus_addr_ok) t_addr_done = 1;
            end else begin
                if (bus_data_ok) begin
                    if (!flush && !t_doomed) begin nv = 1; ni = bus_rdata; end
                    t_active = 0;
                end else if (flush) begin
                    t_doomed = 1;
                end
            end
            m_valid = nv; m_adel = na; m_inst = ni;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("bus_req",    32'(bus_req),    32'(t_active && !t_addr_done));
            chk("bus_addr",   bus_addr,        m_addr);
            chk("inst_valid", 32'(inst_valid), 32'(m_valid));
            chk("inst_o",     inst_o,          m_inst);
            chk("stall_o",    32'(stall_o),    32'(!m_valid && (t_active || (fetch_en && !flush))));
`ifdef IFETCH_ALIGN_CHECK_EN
            chk("adel_o",     32'(adel_o),     32'(m_adel));
`endif
        end
    end

    task automatic cyc(input bit fe, input logic [31:0] pc, input bit fl,
                       input bit aok, input bit dok, input logic [31:0] rd);
        fetch_en = fe; pc_i = pc; flush = fl;
        bus_addr_ok = aok; bus_data_ok = dok; bus_rdata = rd;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1; pc_i = 0; fetch_en = 0; flush = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_addr",   bus_addr,        RV);
        chk("rst_bus_req",    32'(bus_req),    0);
        chk("rst_inst_o",     inst_o,          0);
        chk("rst_inst_valid", 32'(inst_valid), 0);
        rst = 0;

        // Basic fetch: 3-cycle latency, single pulse
        cyc(1, 32'hBFC00000, 0, 0, 0, 0);
        chk("t1_req", 32'(bus_req), 1);
        chk("t1_addr", bus_addr, 32'hBFC00000);
        chk("t1_stall", 32'(stall_o), 1);
        cyc(1, 32'hBFC00000, 0, 1, 0, 0);
        chk("t1_wait_stall", 32'(stall_o), 1);
        cyc(1, 32'hBFC00000, 0, 0, 1, 32'h3C080001);
        chk("t1_valid", 32'(inst_valid), 1);
        chk("t1_inst", inst_o, 32'h3C080001);
        chk("t1_stall_lo", 32'(stall_o), 0);
        cyc(0, 32'hBFC00004, 0, 0, 0, 0);
        chk("t1_pulse", 32'(inst_valid), 0);

        // Delayed addr_ok: request held stable, early data_ok ignored
        cyc(1, 32'hBFC00004, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'hBFC00004, 0, 0, i[0], 32'h55555555);
            chk("t2_req_hold", 32'(bus_req), 1);
            chk("t2_addr_hold", bus_addr, 32'hBFC00004);
            chk("t2_no_valid", 32'(inst_valid), 0);
        end
        cyc(1, 32'hBFC00004, 0, 1, 0, 0);
        cyc(1, 32'hBFC00004, 0, 0, 1, 32'h11112222);
        chk("t2_inst", inst_o, 32'h11112222);
        cyc(0, 32'hBFC00008, 0, 0, 0, 0);

        // Flush in WAIT, stale data dropped, next fetch returns its own data
        cyc(1, 32'hBFC00008, 0, 0, 0, 0);
        cyc(1, 32'hBFC00008, 0, 1, 0, 0);
        cyc(0, 32'hBFC00380, 1, 0, 0, 0);
        cyc(1, 32'hBFC00380, 0, 0, 1, 32'hDEADBEEF);
        chk("t3_drop", 32'(inst_valid), 0);
        cyc(1, 32'hBFC00380, 0, 0, 0, 0);
        chk("t3_addr", bus_addr, 32'hBFC00380);
        cyc(1, 32'hBFC00380, 0, 1, 0, 0);
        cyc(1, 32'hBFC00380, 0, 0, 1, 32'h8C020010);
        chk("t3_valid", 32'(inst_valid), 1);
        chk("t3_inst", inst_o, 32'h8C020010);
        cyc(0, 32'hBFC00384, 0, 0, 0, 0);

        // Flush together with data_ok: discarded, back in IDLE next cycle
        cyc(1, 32'hBFC0000C, 0, 0, 0, 0);
        cyc(1, 32'hBFC0000C, 0, 1, 0, 0);
        cyc(0, 32'hBFC0000C, 1, 0, 1, 32'hCAFEF00D);
        chk("t4_no_valid", 32'(inst_valid), 0);
        chk("t4_inst_kept", inst_o, 32'h8C020010);
        cyc(1, 32'hBFC00010, 0, 0, 0, 0);
        chk("t4_idle_restart", 32'(bus_req), 1);
        chk("t4_addr", bus_addr, 32'hBFC00010);
        cyc(1, 32'hBFC00010, 0, 1, 0, 0);
        cyc(1, 32'hBFC00010, 0, 0, 1, 32'h24420001);
        chk("t4_inst", inst_o, 32'h24420001);
        cyc(0, 32'hBFC00014, 0, 0, 0, 0);

        // Flush during ADDR: handshake completes, data dropped
        cyc(1, 32'hBFC00030, 0, 0, 0, 0);
        cyc(0, 32'hBFC00030, 1, 0, 0, 0);
        chk("t5_req_after_flush", 32'(bus_req), 1);
        cyc(0, 32'hBFC00030, 0, 1, 0, 0);
        cyc(0, 32'hBFC00030, 0, 0, 1, 32'hBAADF00D);
        chk("t5_drop", 32'(inst_valid), 0);

        // Flush in IDLE suppresses a new request
        cyc(1, 32'hBFC00040, 1, 0, 0, 0);
        chk("t6_suppress", 32'(bus_req), 0);
        cyc(0, 32'hBFC00040, 0, 0, 0, 0);

        // Asynchronous reset while in WAIT; stray data_ok afterwards
        cyc(1, 32'hBFC00020, 0, 0, 0, 0);
        cyc(1, 32'hBFC00020, 0, 1, 0, 0);
        fetch_en = 0; bus_addr_ok = 0;
        #2 rst = 1;
        #1;
        chk("t7_rst_req", 32'(bus_req), 0);
        chk("t7_rst_addr", bus_addr, RV);
        chk("t7_rst_inst", inst_o, 0);
        chk("t7_rst_valid", 32'(inst_valid), 0);
        chk("t7_rst_stall", 32'(stall_o), 0);
        rst = 0;
        @(posedge clk); #1;
        cyc(0, 32'hBFC00020, 0, 0, 1, 32'h12345678);
        chk("t7_stray", 32'(inst_valid), 0);
        chk("t7_stray_req", 32'(bus_req), 0);

`ifdef IFETCH_ALIGN_CHECK_EN
        // Misaligned fetch raises AdEL without touching the bus
        cyc(1, 32'hBFC00002, 0, 0, 0, 0);
        chk("t8_no_req", 32'(bus_req), 0);
        chk("t8_adel", 32'(adel_o), 1);
        chk("t8_valid", 32'(inst_valid), 1);
        chk("t8_inst", inst_o, 0);
        cyc(0, 32'hBFC00002, 0, 0, 0, 0);
        chk("t8_adel_pulse", 32'(adel_o), 0);
`endif

        cyc(0, 0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
